// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding and
// word-length select codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from an external FIFO and shifts out
// start, 5..8 data bits LSB-first, optional parity and 1/1.5/2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLEAR,
  input  logic       TXTICK,
  input  logic       TXSTART,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] FIFO_Q,
  input  logic       FIFO_EMPTY,
  output logic       FIFO_READ,
  output logic       SOUT,
  output logic       TX_BUSY,
  output logic       TX_DONE
);

  localparam int TCW = $clog2(2 * OVERSAMPLE);
  localparam logic [TCW-1:0] LAST_1  = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] LAST_15 = TCW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] LAST_2  = TCW'(2 * OVERSAMPLE - 1);

  tx_state_e      state_q, state_d;
  logic [TCW-1:0] tick_q, tick_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     data_q;
  logic [1:0]     wls_q;
  logic           stb_q, pen_q, eps_q, sp_q;
  logic           sout_q, sout_d;
  logic           busy_q;
  logic           done_q, done_d;
  logic           load;
  logic           period_done;

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5 + int'(wls)) x = x ^ data[i];
    end
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

  // Only the stop period can be longer than one bit; 1.5 stop bits exist only for 5-bit words.
  function automatic logic [TCW-1:0] tick_last(input tx_state_e st, input logic stb,
                                               input logic [1:0] wls);
    if (st != ST_STOP || !stb) return LAST_1;
    return (wls == WLS_5) ? LAST_15 : LAST_2;
  endfunction

  always_comb begin
    load        = !RST && !CLEAR && (state_q == ST_IDLE) && TXSTART && !FIFO_EMPTY;
    period_done = TXTICK && (tick_q == tick_last(state_q, stb_q, wls_q));
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    done_d      = 1'b0;
    if (state_q != ST_IDLE && TXTICK) tick_d = period_done ? '0 : tick_q + TCW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (period_done) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (period_done) begin
          if (bit_q == {1'b0, wls_q} + 3'd4) begin
            state_d = pen_q ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: if (period_done) state_d = ST_STOP;
      ST_STOP: begin
        if (period_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (CLEAR) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      bit_d   = '0;
      done_d  = 1'b0;
    end
    // Line level follows the state being entered so SOUT is registered with no extra lag.
    unique case (state_d)
      ST_START:  sout_d = 1'b0;
      ST_DATA:   sout_d = data_q[bit_d];
      ST_PARITY: sout_d = parity_bit(data_q, wls_q, eps_q, sp_q);
      default:   sout_d = 1'b1;
    endcase
    if (BC) sout_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sout_q  <= sout_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      if (load) begin
        data_q <= FIFO_Q;
        wls_q  <= WLS;
        stb_q  <= STB;
        pen_q  <= PEN;
        eps_q  <= EPS;
        sp_q   <= SP;
      end
    end
  end

  assign FIFO_READ = load;
  assign SOUT      = sout_q;
  assign TX_BUSY   = busy_q;
  assign TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: expected frames are built per tick
// from the byte and line settings, and a monitor compares each captured frame.
module tb_uart_tx_serializer;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       stb, pen, eps, sp;
  } ent_t;

  typedef struct {
    logic [255:0] bits;
    int           len;
  } frm_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLEAR = 1'b0;
  logic       TXTICK = 1'b0;
  logic       TXSTART = 1'b0;
  logic [1:0] WLS = '0;
  logic       STB = 1'b0, PEN = 1'b0, EPS = 1'b0, SP = 1'b0, BC = 1'b0;
  logic [7:0] FIFO_Q = '0;
  logic       FIFO_EMPTY = 1'b1;
  logic       FIFO_READ, SOUT, TX_BUSY, TX_DONE;

  uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .TXTICK(TXTICK), .TXSTART(TXSTART),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_READ(FIFO_READ),
    .SOUT(SOUT), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
  );

  always #5 CLK = ~CLK;

  int   cycle = 0;
  int   n_chk = 0, n_pass = 0;
  int   n_reads = 0, n_done = 0;
  int   tick_pct = 100;
  bit   mon_en = 1'b0;
  bit   rd_pending = 1'b0;
  bit   capturing = 1'b0;
  ent_t fifo[$];
  frm_t expq[$];
  frm_t cap;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference frame: one entry per TXTICK, level the line must hold during that tick.
  function automatic frm_t model(input ent_t e);
    frm_t f;
    int   nb, ones, stop_ticks;
    logic par;
    f.bits = '0;
    f.len  = 0;
    nb     = 5 + int'(e.wls);
    ones   = 0;
    for (int t = 0; t < OS; t++) begin f.bits[f.len] = 1'b0; f.len++; end
    for (int b = 0; b < nb; b++) begin
      ones += int'(e.data[b]);
      for (int t = 0; t < OS; t++) begin f.bits[f.len] = e.data[b]; f.len++; end
    end
    if (e.pen) begin
      if (e.sp) par = ~e.eps;
      else if (e.eps) par = (ones % 2 == 1);
      else par = (ones % 2 == 0);
      for (int t = 0; t < OS; t++) begin f.bits[f.len] = par; f.len++; end
    end
    if (!e.stb) stop_ticks = OS;
    else if (e.wls == 2'b00) stop_ticks = OS + OS / 2;
    else stop_ticks = 2 * OS;
    for (int t = 0; t < stop_ticks; t++) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  function automatic ent_t mk(input logic [7:0] d, input logic [1:0] w, input logic stb,
                              input logic pen, input logic eps, input logic sp);
    ent_t e;
    e.data = d; e.wls = w; e.stb = stb; e.pen = pen; e.eps = eps; e.sp = sp;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic push(input ent_t e, input bit expect_frame);
    fifo.push_back(e);
    if (expect_frame) expq.push_back(model(e));
  endtask

  // Driver: FIFO model, per-frame line settings (scrambled while busy) and TXTICK.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (rd_pending) begin
        if (fifo.size() > 0) fifo.delete(0);
        rd_pending = 1'b0;
      end
      if (fifo.size() > 0) begin FIFO_Q = fifo[0].data; FIFO_EMPTY = 1'b0; end
      else begin FIFO_Q = 8'h00; FIFO_EMPTY = 1'b1; end
      if (TX_BUSY || fifo.size() == 0) {WLS, STB, PEN, EPS, SP} = 6'($urandom);
      else {WLS, STB, PEN, EPS, SP} = {fifo[0].wls, fifo[0].stb, fifo[0].pen, fifo[0].eps, fifo[0].sp};
      TXTICK = ($urandom_range(0, 99) < tick_pct);
    end
  end

  // Monitor: captures SOUT once per tick from START entry up to TX_DONE.
  initial begin
    frm_t e;
    forever begin
      @(negedge CLK);
      if (!mon_en) capturing = 1'b0;
      if (TX_DONE) begin
        n_done++;
        if (capturing) begin
          capturing = 1'b0;
          if (expq.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            e = expq.pop_front();
            n_chk++;
            if (e.len == cap.len && e.bits == cap.bits) n_pass++;
            else $display("FAIL frame: got len %0d bits %h, required len %0d bits %h",
                          cap.len, cap.bits, e.len, e.bits);
          end
        end
        if (mon_en && TXSTART && fifo.size() > 0) chk("b2b_read", int'(FIFO_READ), 1);
      end else if (capturing && TXTICK) begin
        if (cap.len < 256) cap.bits[cap.len] = SOUT;
        cap.len++;
      end
      if (FIFO_READ) begin
        rd_pending = 1'b1;
        n_reads++;
        chk("read_while_busy", int'(TX_BUSY), 0);
        if (mon_en) begin cap.bits = '0; cap.len = 0; capturing = 1'b1; end
      end
    end
  end

  task automatic wait_read(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (FIFO_READ) begin c = cycle; return; end
    end
    chk("read_timeout", 0, 1);
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (TX_DONE) begin c = cycle; return; end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40000; i++) begin
      @(negedge CLK);
      if (fifo.size() == 0 && !TX_BUSY && !capturing) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int c0, c1, r0, d0, cnt;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_sout", int'(SOUT), 1);
    chk("rst_busy", int'(TX_BUSY), 0);
    chk("rst_done", int'(TX_DONE), 0);
    chk("rst_read", int'(FIFO_READ), 0);
    step();
    RST = 1'b0;

    // Empty FIFO or TXSTART low: no pop
    TXSTART = 1'b1;
    cnt = n_reads;
    repeat (40) step();
    chk("empty_no_read", n_reads - cnt, 0);
    TXSTART = 1'b0;
    mon_en  = 1'b1;
    push(mk(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    repeat (40) step();
    chk("txstart_low_no_read", n_reads - cnt, 0);

    // CLEAR beats a load
    CLEAR = 1'b1;
    TXSTART = 1'b1;
    @(negedge CLK);
    chk("clear_blocks_load", int'(FIFO_READ), 0);
    step();
    CLEAR = 1'b0;

    // 8N1 0xA5 latency
    wait_read(c0);
    wait_done(c1);
    chk("a5_done_latency", c1 - c0, 161);
    drain();
    chk("a5_reads", n_reads - cnt, 1);

    // Parity and stop-length cases, back to back
    r0 = n_reads; d0 = n_done;
    push(mk(8'h35, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    push(mk(8'h35, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    push(mk(8'h35, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1);
    push(mk(8'h1B, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    push(mk(8'hC6, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();
    chk("b2b_reads", n_reads - r0, 5);
    chk("b2b_dones", n_done - d0, 5);

    // Random frames, sparse ticks, random arrival
    tick_pct = 50;
    r0 = n_reads;
    for (int k = 0; k < 20; k++) begin
      push(rnd_ent(), 1'b1);
      repeat ($urandom_range(0, 300)) step();
    end
    drain();
    chk("rand50_reads", n_reads - r0, 20);

    // Random frames with TXSTART toggling mid-frame
    tick_pct = 25;
    r0 = n_reads;
    for (int k = 0; k < 8; k++) begin
      push(rnd_ent(), 1'b1);
      repeat ($urandom_range(0, 400)) begin
        step();
        TXSTART = 1'($urandom_range(0, 1));
      end
    end
    step();
    TXSTART = 1'b1;
    drain();
    chk("rand25_reads", n_reads - r0, 8);

    // Break mid-DATA, frame timing unchanged
    mon_en = 1'b0;
    tick_pct = 100;
    step();
    push(mk(8'($urandom), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    wait_read(c0);
    repeat (36) @(negedge CLK);
    step();
    BC = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge CLK);
      @(negedge CLK);
      if (SOUT !== 1'b0) cnt++;
    end
    step();
    BC = 1'b0;
    chk("break_sout_low", cnt, 0);
    wait_done(c1);
    chk("break_timing", c1 - c0, 161);
    drain();

    // CLEAR mid-DATA
    push(mk(8'($urandom), 2'b11, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0);
    wait_read(c0);
    repeat (40) @(negedge CLK);
    step();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    @(negedge CLK);
    chk("clear_sout", int'(SOUT), 1);
    chk("clear_busy", int'(TX_BUSY), 0);
    d0 = n_done;
    repeat (200) @(negedge CLK);
    chk("clear_no_done", n_done - d0, 0);

    // Reset during PARITY, then a clean 8N1 frame
    push(mk(8'($urandom), 2'b11, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0);
    wait_read(c0);
    repeat (150) @(negedge CLK);
    step();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_sout", int'(SOUT), 1);
    chk("rst_mid_busy", int'(TX_BUSY), 0);
    step();
    RST = 1'b0;
    mon_en = 1'b1;
    push(mk(8'($urandom), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    drain();
    repeat (3) step();

    chk("expected_frames_left", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
